// File: rtl/dm_timer_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an optional
// memory-mapped countdown timer with level interrupt (enabled by DM_TIMER_EN).
module dm_timer_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] TIMER_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        addr_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = 32;

    // Configuration sanity: power-of-two RAM that stays below the timer block.
    if ((DEPTH & (DEPTH - 1)) != 0 || 32'(DEPTH * 4) > TIMER_BASE) begin : g_bad_cfg
        $error("dm_timer_responder: invalid DEPTH/TIMER_BASE combination");
    end

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] idx;
    logic          misaligned;
    logic          ram_hit;
    logic          tmr_hit;
    logic          wr_ok;

    assign idx        = addr[AW+1:2];
    assign misaligned = (addr[1:0] != 2'b00);
    assign ram_hit    = (addr < 32'(DEPTH * 4));
    assign addr_err   = misaligned | ~(ram_hit | tmr_hit);
    assign wr_ok      = memwrite & ~addr_err;

    // RAM array: fully cleared by reset, written on accepted stores.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok && ram_hit) begin
            mem[idx] <= writedata;
        end
    end

`ifdef DM_TIMER_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    ctrl_q, ctrl_d;
    logic [DW-1:0] preset_q, preset_d;
    logic [DW-1:0] count_q, count_d;
    logic          irq_q, irq_d;
    logic          ctrl_wr, preset_wr, en;

    assign tmr_hit   = (addr == TIMER_BASE) | (addr == TIMER_BASE + 32'd4) |
                       (addr == TIMER_BASE + 32'd8);
    assign ctrl_wr   = wr_ok & (addr == TIMER_BASE);
    assign preset_wr = wr_ok & (addr == TIMER_BASE + 32'd4);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Enable as seen this edge: a CTRL store takes effect immediately so LOAD follows the write.
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;
        en       = ctrl_wr ? writedata[0] : ctrl_q[0];

        if (ctrl_wr) begin
            irq_d = 1'b0;
        end

        if (!en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_LOAD;
                S_LOAD: begin
                    count_d = preset_q;
                    state_d = S_CNT;
                end
                S_CNT: begin
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        count_d = '0;
                        state_d = S_INT;
                        irq_d   = ctrl_q[3];
                    end
                end
                S_INT: begin
                    if (ctrl_q[2:1] == 2'b01) begin
                        state_d = S_LOAD;
                    end else begin
                        ctrl_d[0] = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Core stores override the FSM's own CTRL update.
        if (ctrl_wr) begin
            ctrl_d = writedata[3:0];
        end
        if (preset_wr) begin
            preset_d = writedata;
        end
    end

    assign irq = irq_q;

    always_comb begin
        readdata = '0;
        if (!addr_err) begin
            if (ram_hit) begin
                readdata = mem[idx];
            end else if (addr == TIMER_BASE) begin
                readdata = {28'd0, ctrl_q};
            end else if (addr == TIMER_BASE + 32'd4) begin
                readdata = preset_q;
            end else begin
                readdata = count_q;
            end
        end
    end
`else
    assign tmr_hit = 1'b0;
    assign irq     = 1'b0;

    always_comb begin
        readdata = '0;
        if (!addr_err) begin
            readdata = mem[idx];
        end
    end
`endif

`ifndef SYNTHESIS
    // Store trace for simulation logs.
    always_ff @(posedge clk) begin
        if (reset && wr_ok) begin
            $display("@%h: *%h <= %h", pc, addr, writedata);
        end
    end
`endif

endmodule

// File: tb/tb_dm_timer_responder.sv
// Directed self-checking bench for dm_timer_responder; timer steps run when DM_TIMER_EN is defined.
module tb_dm_timer_responder;

    localparam logic [31:0] TB = 32'h0000_7F00;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        memwrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    dm_timer_responder #(.DEPTH(1024), .TIMER_BASE(TB)) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .addr_err  (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp, input logic exp_err);
        addr = a;
        #1;
        chk({tag, "_data"}, readdata, exp);
        chk({tag, "_err"}, 32'(addr_err), 32'(exp_err));
    endtask

    initial begin
        reset     = 1'b0;
        pc        = 32'h0;
        memwrite  = 1'b0;
        addr      = 32'h0;
        writedata = 32'h0;
        #12;
        chk("irq_in_reset", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Post-reset decode and boundaries
        rd("rd_0", 32'h0, 32'h0, 1'b0);
        rd("rd_ffc", 32'hFFC, 32'h0, 1'b0);
        rd("rd_1000", 32'h1000, 32'h0, 1'b1);

        // Store, with read-during-write showing the old value
        pc        = 32'h3000;
        addr      = 32'h10;
        writedata = 32'h1234_5678;
        memwrite  = 1'b1;
        #1;
        chk("rdw_old", readdata, 32'h0);
        tick();
        memwrite = 1'b0;
        rd("rd_10", 32'h10, 32'h1234_5678, 1'b0);

        // Misaligned store is dropped
        addr = 32'h13;
        #1;
        chk("mis_err", 32'(addr_err), 32'd1);
        wr(32'h13, 32'hDEAD_BEEF);
        rd("rd_13", 32'h13, 32'h0, 1'b1);
        rd("rd_10_kept", 32'h10, 32'h1234_5678, 1'b0);

        // Top word, and an out-of-range store that must not alias word 0
        wr(32'hFFC, 32'hA5A5_A5A5);
        rd("rd_ffc_w", 32'hFFC, 32'hA5A5_A5A5, 1'b0);
        wr(32'h1000, 32'h5555_5555);
        rd("rd_0_noalias", 32'h0, 32'h0, 1'b0);

`ifdef DM_TIMER_EN
        // Register access: COUNT read-only, CTRL upper bits read 0
        wr(TB + 32'd4, 32'd3);
        rd("preset_rd", TB + 32'd4, 32'd3, 1'b0);
        wr(TB + 32'd8, 32'h55);
        rd("count_ro", TB + 32'd8, 32'h0, 1'b0);

        // One-shot, PRESET=3: irq after the 4th edge following the CTRL write
        wr(TB, 32'hFFFF_FFF9);
        addr = TB + 32'd8;
        tick();
        chk("os_cnt1", readdata, 32'd3);
        tick();
        chk("os_cnt2", readdata, 32'd2);
        tick();
        chk("os_cnt3", readdata, 32'd1);
        chk("os_irq_lo", 32'(irq), 32'd0);
        tick();
        chk("os_irq_hi", 32'(irq), 32'd1);
        chk("os_cnt0", readdata, 32'd0);
        tick();
        rd("os_ctrl", TB, 32'h8, 1'b0);
        chk("os_irq_hold", 32'(irq), 32'd1);
        wr(TB, 32'h0);
        chk("ctrl_clr_irq", 32'(irq), 32'd0);

        // Auto-reload, PRESET=2: irq period of 4 cycles
        wr(TB + 32'd4, 32'd2);
        wr(TB, 32'hB);
        addr = TB + 32'd8;
        tick();
        tick();
        chk("ar_irq_lo", 32'(irq), 32'd0);
        tick();
        chk("ar_irq_hi1", 32'(irq), 32'd1);
        wr(TB, 32'hB);
        addr = TB + 32'd8;
        #1;
        chk("ar_irq_clr", 32'(irq), 32'd0);
        tick();
        tick();
        chk("ar_cnt1", readdata, 32'd1);
        chk("ar_irq_lo2", 32'(irq), 32'd0);
        tick();
        chk("ar_irq_hi2", 32'(irq), 32'd1);
        wr(TB, 32'h0);
        chk("ar_stop_irq", 32'(irq), 32'd0);
        tick();
        tick();
        rd("ar_idle_cnt", TB + 32'd8, 32'd0, 1'b0);

        // PRESET=0 goes straight to INT without wrapping
        wr(TB + 32'd4, 32'd0);
        wr(TB, 32'h9);
        addr = TB + 32'd8;
        tick();
        tick();
        chk("p0_irq", 32'(irq), 32'd1);
        chk("p0_cnt", readdata, 32'd0);
        wr(TB, 32'h0);

        // Asynchronous reset in the middle of a count
        wr(TB + 32'd4, 32'd10);
        wr(TB, 32'h9);
        addr = TB + 32'd8;
        for (int i = 0; i < 6; i++) tick();
        chk("mid_cnt5", readdata, 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_cnt", readdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        rd("rst_ctrl", TB, 32'h0, 1'b0);
        rd("rst_ram", 32'h10, 32'h0, 1'b0);
`else
        // Timer window decodes as unmapped in this build
        rd("tmr_unmapped", TB, 32'h0, 1'b1);
        wr(TB, 32'h9);
        wr(TB + 32'd4, 32'd1);
        rd("tmr_preset_unmapped", TB + 32'd4, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("irq_tied", 32'(irq), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        rd("rst_ram", 32'h10, 32'h0, 1'b0);
        rd("rst_ram_ffc", 32'hFFC, 32'h0, 1'b0);
`endif
        @(negedge clk);
        reset = 1'b1;
        tick();
        wr(32'h20, 32'hCAFE_F00D);
        rd("post_rst_wr", 32'h20, 32'hCAFE_F00D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
